// File: rtl/v810_ebus_mem_pkg.sv
// Shared types and helpers for the V810 external-bus memory responder.
package v810_ebus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } ebus_state_t;

    localparam logic DW_32 = 1'b0;
    localparam logic DW_16 = 1'b1;

    // Number of address bits needed to select one of n regions (n=1 -> 0).
    function automatic int unsigned REG_BITS(input int unsigned n);
        int unsigned b;
        b = 0;
        for (int unsigned i = 0; i < 4; i++) begin
            if ((32'd1 << i) < n) b = i + 1;
        end
        return b;
    endfunction

endpackage

// File: rtl/v810_ebus_mem_array.sv
// 32-bit synchronous RAM with per-byte write enables.
module v810_ebus_mem_array #(
  parameter int unsigned IW        = 11,
  parameter string       INIT_FILE = ""
) (
  input  logic          i_clk,
  input  logic          i_ce,
  input  logic [IW-1:0] i_rd_addr,
  output logic [31:0]   o_rd_data,
  input  logic [IW-1:0] i_wr_addr,
  input  logic [3:0]    i_we,
  input  logic [31:0]   i_wr_data
);

  logic [31:0] r_mem [0:(1 << IW)-1];
  logic [31:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_ce) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (i_we[i]) r_mem[i_wr_addr][8*i +: 8] <= i_wr_data[8*i +: 8];
      end
      r_q <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_q;

endmodule

// File: rtl/v810_ebus_mem.sv
// V810 external-bus memory responder: per-region wait states and 32/16-bit sizing.
// Optional write protection enabled by defining V810_EBUS_MEM_WPROT_EN.
module v810_ebus_mem
    import v810_ebus_pkg::*;
#(
    parameter int unsigned AW        = 10,
    parameter int unsigned NREG      = 2,
    parameter int unsigned WSW       = 4,
    parameter string       INIT_FILE = ""
) (
    input  logic                CLK,
    input  logic                RES,
    input  logic                CE,
    input  logic [31:0]         A,
    input  logic [31:0]         D_O,
    output logic [31:0]         D_I,
    input  logic [3:0]          BEn,
    input  logic                DAn,
    input  logic                MRQn,
    input  logic                RW,
    input  logic                BCYSTn,
    output logic                READYn,
    output logic                SZRQn,
    input  logic [NREG*WSW-1:0] CFG_WS,
    input  logic [NREG-1:0]     CFG_DW16,
    input  logic [NREG-1:0]     WPROT,
    output logic                WPVIOL
);

    localparam int unsigned RB  = REG_BITS(NREG);
    localparam int unsigned RBW = (RB == 0) ? 1 : RB;
    localparam int unsigned IW  = AW + RB;

    ebus_state_t    r_state;
    logic [WSW-1:0] r_cnt;
    logic [IW-1:0]  r_idx;
    logic [RBW-1:0] r_reg;
    logic [3:0]     r_ben;
    logic           r_rw;
    logic           r_a1;
    logic           r_dw;
    logic           r_readyn;
    logic           r_szrqn;
    logic [31:0]    r_dhold;

    logic [RBW-1:0] w_reg;
    logic [IW-1:0]  w_idx;
    logic [WSW-1:0] w_ws;
    logic           w_dw;
    logic           w_t1;
    logic           w_start;
    logic [IW-1:0]  w_rd_addr;
    logic [31:0]    w_q;
    logic [15:0]    w_half;
    logic [31:0]    w_steer;
    logic [3:0]     w_lanes;
    logic [3:0]     w_we;
    logic [31:0]    w_wdata;
    logic           w_prot;
    logic           w_unused;

    generate
        if (RB == 0) begin : g_one_region
            assign w_reg = '0;
            assign w_idx = A[AW+1:2];
        end else begin : g_multi_region
            assign w_reg = A[31 -: RB];
            assign w_idx = {A[31 -: RB], A[AW+1:2]};
        end
    endgenerate

    assign w_ws      = CFG_WS[w_reg*WSW +: WSW];
    assign w_dw      = CFG_DW16[w_reg];
    assign w_t1      = !BCYSTn && !MRQn;
    assign w_start   = ((r_state == IDLE) || (r_state == ACK)) && w_t1;
    // Read address looks one cycle ahead so data is ready in ACK.
    assign w_rd_addr = w_start ? w_idx : r_idx;

    always_ff @(posedge CLK) begin
        if (CE) begin
            if (RES) begin
                r_state  <= IDLE;
                r_readyn <= 1'b1;
                r_szrqn  <= 1'b1;
                r_dhold  <= '0;
            end else begin
                r_readyn <= 1'b1;
                r_szrqn  <= 1'b1;
                if (r_state == ACK) r_dhold <= w_steer;
                case (r_state)
                    IDLE, ACK: begin
                        if (w_t1) begin
                            r_idx <= w_idx;
                            r_reg <= w_reg;
                            r_rw  <= RW;
                            r_ben <= BEn;
                            r_a1  <= A[1];
                            r_dw  <= w_dw;
                            if (w_ws == '0) begin
                                r_state  <= ACK;
                                r_readyn <= 1'b0;
                                r_szrqn  <= ~w_dw;
                            end else begin
                                r_state <= WAIT;
                                r_cnt   <= w_ws;
                            end
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                    WAIT: begin
                        if (!DAn) begin
                            if (r_cnt == WSW'(1)) begin
                                r_state  <= ACK;
                                r_readyn <= 1'b0;
                                r_szrqn  <= ~r_dw;
                            end else begin
                                r_cnt <= r_cnt - WSW'(1);
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign w_half  = r_a1 ? w_q[31:16] : w_q[15:0];
    assign w_steer = (r_dw == DW_16) ? {w_half, w_half} : w_q;
    assign D_I     = (r_state == ACK) ? w_steer : r_dhold;
    assign READYn  = r_readyn;
    assign SZRQn   = r_szrqn;

    always_comb begin
        w_lanes = ~r_ben;
        if (r_dw == DW_16) w_lanes = r_a1 ? {~r_ben[1:0], 2'b00} : {2'b00, ~r_ben[1:0]};
    end

    assign w_wdata = (r_dw == DW_16) ? {D_O[15:0], D_O[15:0]} : D_O;
    assign w_we    = ((r_state == ACK) && !r_rw && !RES && !w_prot) ? w_lanes : '0;

`ifdef V810_EBUS_MEM_WPROT_EN
    logic r_wpviol;

    assign w_prot   = WPROT[r_reg];
    assign w_unused = ^A;

    always_ff @(posedge CLK) begin
        if (CE) begin
            if (RES) r_wpviol <= 1'b0;
            else if ((r_state == ACK) && !r_rw && w_prot) r_wpviol <= 1'b1;
        end
    end

    assign WPVIOL = r_wpviol;
`else
    assign w_prot   = 1'b0;
    assign w_unused = ^{A, WPROT, r_reg};
    assign WPVIOL   = 1'b0;
`endif

    v810_ebus_mem_array #(
        .IW        (IW),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .i_clk     (CLK),
        .i_ce      (CE),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_q),
        .i_wr_addr (r_idx),
        .i_we      (w_we),
        .i_wr_data (w_wdata)
    );

endmodule

// File: tb/tb_v810_ebus_mem.sv
// Directed scoreboard bench for v810_ebus_mem (default parameters, two regions).
module tb_v810_ebus_mem;

`ifdef V810_EBUS_MEM_WPROT_EN
    localparam logic WP_EN = 1'b1;
`else
    localparam logic WP_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RES, CE;
    logic [31:0] A, D_O, D_I;
    logic [3:0]  BEn;
    logic        DAn, MRQn, RW, BCYSTn, READYn, SZRQn;
    logic [7:0]  CFG_WS;
    logic [1:0]  CFG_DW16, WPROT;
    logic        WPVIOL;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        chk_data;
        logic        szrqn;
        int          lat;
    } sb_t;
    sb_t sb[$];

    v810_ebus_mem #(
        .AW   (10),
        .NREG (2),
        .WSW  (4)
    ) dut (
        .CLK      (CLK),
        .RES      (RES),
        .CE       (CE),
        .A        (A),
        .D_O      (D_O),
        .D_I      (D_I),
        .BEn      (BEn),
        .DAn      (DAn),
        .MRQn     (MRQn),
        .RW       (RW),
        .BCYSTn   (BCYSTn),
        .READYn   (READYn),
        .SZRQn    (SZRQn),
        .CFG_WS   (CFG_WS),
        .CFG_DW16 (CFG_DW16),
        .WPROT    (WPROT),
        .WPVIOL   (WPVIOL)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int ws_of(input logic [31:0] addr);
        return int'(addr[31] ? CFG_WS[7:4] : CFG_WS[3:0]);
    endfunction

    task automatic push(input string tag, input logic [31:0] addr, input logic [31:0] data,
                        input logic chk_data, input int extra);
        sb_t e;
        e.tag      = tag;
        e.data     = data;
        e.chk_data = chk_data;
        e.szrqn    = ~CFG_DW16[addr[31]];
        e.lat      = ws_of(addr) + 1 + extra;
        sb.push_back(e);
    endtask

    task automatic start(input logic [31:0] addr, input logic rw, input logic [3:0] ben,
                         input logic [31:0] dout, input logic dan_t1);
        A = addr; RW = rw; BEn = ben; D_O = dout;
        BCYSTn = 1'b0; MRQn = 1'b0; DAn = dan_t1;
        @(posedge CLK); #1;
        BCYSTn = 1'b1; DAn = 1'b0;
    endtask

    task automatic wait_ack(input int pre);
        int  n;
        bit  got;
        sb_t e;
        n = pre; got = 1'b0;
        while (!got && n < 40) begin
            @(negedge CLK);
            n++;
            if (READYn === 1'b0) got = 1'b1;
        end
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_ack_seen"}, 32'(got), 32'd1);
            if (got) begin
                chk({e.tag, "_latency"}, 32'(n), 32'(e.lat));
                chk({e.tag, "_szrqn"}, 32'(SZRQn), 32'(e.szrqn));
                if (e.chk_data) chk({e.tag, "_data"}, D_I, e.data);
            end
        end
    endtask

    task automatic finish_cycle();
        @(posedge CLK); #1;
        MRQn = 1'b1; BCYSTn = 1'b1; RW = 1'b1; BEn = 4'hF;
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        push(tag, addr, exp, 1'b1, 0);
        start(addr, 1'b1, 4'h0, 32'h0, 1'b0);
        wait_ack(0);
        finish_cycle();
    endtask

    task automatic wr(input string tag, input logic [31:0] addr, input logic [3:0] ben,
                      input logic [31:0] dout);
        push(tag, addr, 32'h0, 1'b0, 0);
        start(addr, 1'b0, ben, dout, 1'b0);
        wait_ack(0);
        finish_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        RES = 1'b1; CE = 1'b1; A = '0; D_O = '0; BEn = 4'hF; DAn = 1'b1;
        MRQn = 1'b1; RW = 1'b1; BCYSTn = 1'b1;
        CFG_WS = 8'h30; CFG_DW16 = 2'b10; WPROT = 2'b00;
        repeat (3) @(posedge CLK);
        #1 RES = 1'b0;
        @(negedge CLK);
        chk("reset_readyn", 32'(READYn), 32'd1);
        chk("reset_szrqn", 32'(SZRQn), 32'd1);
        chk("reset_d_i", D_I, 32'h0);
        chk("reset_wpviol", 32'(WPVIOL), 32'd0);
        @(posedge CLK); #1;

        // Region 0: 32-bit, zero wait states
        wr("w32_init", 32'h0000_0004, 4'h0, 32'h1122_3344);
        rd("r32_ws0", 32'h0000_0004, 32'h1122_3344);
        wr("w32_8", 32'h0000_0008, 4'h0, 32'hDEAD_BEEF);

        // Region 1: 16-bit, three wait states
        wr("w16_lo", 32'h8000_0000, 4'hC, 32'h0000_CCDD);
        wr("w16_hi", 32'h8000_0002, 4'hC, 32'h0000_AABB);
        rd("r16_hi", 32'h8000_0002, 32'hAABB_AABB);
        rd("r16_lo", 32'h8000_0000, 32'hCCDD_CCDD);
        wr("w16_1234", 32'h8000_0000, 4'hC, 32'hFFFF_1234);
        rd("r16_lo_new", 32'h8000_0000, 32'h1234_1234);
        rd("r16_hi_keep", 32'h8000_0002, 32'hAABB_AABB);

        // Byte lanes, no-lane write, address aliasing
        wr("w32_lanes", 32'h0000_0004, 4'b1010, 32'h5566_7788);
        wr("w32_ben_f", 32'h0000_0004, 4'hF, 32'h0000_0000);
        rd("r32_alias", 32'h0000_1004, 32'h1166_3388);

        // ws=0 with DAn still high in T1
        push("r_dan_t1", 32'h0000_0008, 32'hDEAD_BEEF, 1'b1, 0);
        start(32'h0000_0008, 1'b1, 4'h0, 32'h0, 1'b1);
        wait_ack(0);
        finish_cycle();

        // Back-to-back reads with two wait states
        CFG_WS = 8'h32;
        push("b2b_first", 32'h0000_0004, 32'h1166_3388, 1'b1, 0);
        push("b2b_second", 32'h0000_0008, 32'hDEAD_BEEF, 1'b1, 0);
        start(32'h0000_0004, 1'b1, 4'h0, 32'h0, 1'b0);
        wait_ack(0);
        start(32'h0000_0008, 1'b1, 4'h0, 32'h0, 1'b0);
        wait_ack(0);
        finish_cycle();

        // DAn high for three cycles in WAIT
        push("dan_stall", 32'h0000_0008, 32'hDEAD_BEEF, 1'b1, 3);
        start(32'h0000_0008, 1'b1, 4'h0, 32'h0, 1'b0);
        DAn = 1'b1;
        repeat (3) @(posedge CLK);
        #1 DAn = 1'b0;
        wait_ack(3);
        finish_cycle();

        // CE low for four cycles in WAIT
        push("ce_stall", 32'h0000_0004, 32'h1166_3388, 1'b1, 4);
        start(32'h0000_0004, 1'b1, 4'h0, 32'h0, 1'b0);
        CE = 1'b0;
        repeat (4) @(posedge CLK);
        #1 CE = 1'b1;
        wait_ack(4);
        finish_cycle();

        // Reset during WAIT of a write: cycle dropped, memory untouched
        start(32'h0000_0008, 1'b0, 4'h0, 32'h0BAD_F00D, 1'b0);
        RES = 1'b1;
        @(posedge CLK); #1;
        RES = 1'b0; MRQn = 1'b1; RW = 1'b1; BEn = 4'hF;
        bad = 0;
        repeat (5) begin
            @(negedge CLK);
            if (READYn !== 1'b1) bad++;
        end
        chk("rst_wait_no_ready", 32'(bad), 32'd0);
        chk("rst_wait_d_i", D_I, 32'h0);
        @(posedge CLK); #1;
        rd("rst_wait_mem", 32'h0000_0008, 32'hDEAD_BEEF);

        // Write protection on region 1
        WPROT = 2'b10;
        wr("w_prot", 32'h8000_0000, 4'hC, 32'h0000_9999);
        rd("r_prot", 32'h8000_0000, WP_EN ? 32'h1234_1234 : 32'h9999_9999);
        chk("wpviol_set", 32'(WPVIOL), 32'(WP_EN));
        wr("w_unprot", 32'h0000_0008, 4'h0, 32'h0102_0304);
        chk("wpviol_sticky", 32'(WPVIOL), 32'(WP_EN));
        RES = 1'b1;
        @(posedge CLK); #1;
        RES = 1'b0;
        @(negedge CLK);
        chk("wpviol_cleared", 32'(WPVIOL), 32'd0);
        @(posedge CLK); #1;
        rd("r_unprot", 32'h0000_0008, 32'h0102_0304);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
